// File: rtl/proc_hier_unpipelined.sv
// rtl/proc_hier_unpipelined.sv - single-cycle 16-bit processor with commit trace outputs
module proc_hier_unpipelined #(
  parameter int IMEM_WORDS = 256,
  parameter int DMEM_WORDS = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        imem_we,
  input  logic [15:0] imem_addr,
  input  logic [15:0] imem_wdata,
  output logic [15:0] pc,
  output logic [15:0] inst,
  output logic        reg_write,
  output logic [2:0]  write_reg,
  output logic [15:0] write_data,
  output logic        mem_read,
  output logic        mem_write,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_data,
  output logic        halt,
  output logic [31:0] cycle_count
);

  localparam int IA = $clog2(IMEM_WORDS);
  localparam int DA = $clog2(DMEM_WORDS);

  localparam logic [4:0] OP_HALT = 5'b00000;
  localparam logic [4:0] OP_ADDI = 5'b01000;
  localparam logic [4:0] OP_ST   = 5'b10000;
  localparam logic [4:0] OP_LD   = 5'b10001;
  localparam logic [4:0] OP_ALU  = 5'b11011;
  localparam logic [4:0] OP_LBI  = 5'b11000;
  localparam logic [4:0] OP_BEQZ = 5'b01100;
  localparam logic [4:0] OP_BNEZ = 5'b01101;
  localparam logic [4:0] OP_J    = 5'b00100;

  logic [15:0] r_imem [IMEM_WORDS];
  logic [15:0] r_dmem [DMEM_WORDS];
  logic [15:0] r_regs [8];
  logic [15:0] r_pc;
  logic [31:0] r_cycle;
  logic        r_halted;

  logic [4:0]  w_op;
  logic [2:0]  w_rs_idx;
  logic [2:0]  w_rt_idx;
  logic [2:0]  w_rd_r;
  logic [15:0] w_imm5;
  logic [15:0] w_imm8;
  logic [15:0] w_disp11;
  logic [15:0] w_rs_val;
  logic [15:0] w_rt_val;
  logic [15:0] w_ea;
  logic [15:0] w_dmem_rdata;
  logic [15:0] w_pc_inc;
  logic [15:0] w_next_pc;
  logic        w_is_halt;
  logic        w_unused;

  // Only the word-index bits of the load address select a location.
  assign w_unused = ^imem_addr;

  assign inst         = r_imem[r_pc[IA:1]];
  assign w_op         = inst[15:11];
  assign w_rs_idx     = inst[10:8];
  assign w_rt_idx     = inst[7:5];
  assign w_rd_r       = inst[4:2];
  assign w_imm5       = {{11{inst[4]}}, inst[4:0]};
  assign w_imm8       = {{8{inst[7]}}, inst[7:0]};
  assign w_disp11     = {{5{inst[10]}}, inst[10:0]};
  assign w_rs_val     = r_regs[w_rs_idx];
  assign w_rt_val     = r_regs[w_rt_idx];
  assign w_ea         = w_rs_val + w_imm5;
  assign w_dmem_rdata = r_dmem[w_ea[DA:1]];
  assign w_pc_inc     = r_pc + 16'd2;

  assign pc          = r_pc;
  assign cycle_count = r_cycle;
  assign halt        = w_is_halt;

  always_comb begin
    reg_write  = 1'b0;
    write_reg  = 3'd0;
    write_data = 16'd0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_addr   = 16'd0;
    mem_data   = 16'd0;
    w_is_halt  = 1'b0;
    w_next_pc  = w_pc_inc;
    // Once halted, nothing commits even if the instruction memory is reloaded underneath.
    if (r_halted) begin
      w_is_halt = 1'b1;
      w_next_pc = r_pc;
    end else begin
      case (w_op)
        OP_HALT: begin
          w_is_halt = 1'b1;
          w_next_pc = r_pc;
        end
        OP_ADDI: begin
          reg_write  = 1'b1;
          write_reg  = w_rt_idx;
          write_data = w_ea;
        end
        OP_ST: begin
          mem_write = 1'b1;
          mem_addr  = w_ea;
          mem_data  = w_rt_val;
        end
        OP_LD: begin
          mem_read   = 1'b1;
          mem_addr   = w_ea;
          reg_write  = 1'b1;
          write_reg  = w_rt_idx;
          write_data = w_dmem_rdata;
        end
        OP_ALU: begin
          reg_write = 1'b1;
          write_reg = w_rd_r;
          case (inst[1:0])
            2'b00:   write_data = w_rs_val + w_rt_val;
            2'b01:   write_data = w_rt_val - w_rs_val;
            2'b10:   write_data = w_rs_val ^ w_rt_val;
            default: write_data = w_rs_val & w_rt_val;
          endcase
        end
        OP_LBI: begin
          reg_write  = 1'b1;
          write_reg  = w_rs_idx;
          write_data = w_imm8;
        end
        OP_BEQZ: if (w_rs_val == 16'd0) w_next_pc = w_pc_inc + w_imm8;
        OP_BNEZ: if (w_rs_val != 16'd0) w_next_pc = w_pc_inc + w_imm8;
        OP_J:    w_next_pc = w_pc_inc + w_disp11;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pc     <= 16'd0;
      r_cycle  <= 32'd0;
      r_halted <= 1'b0;
      for (int i = 0; i < 8; i++) r_regs[i] <= 16'd0;
    end else begin
      r_cycle <= r_cycle + 32'd1;
      r_pc    <= w_next_pc;
      if (w_is_halt) r_halted <= 1'b1;
      if (reg_write) r_regs[write_reg] <= write_data;
    end
  end

  // Memories keep their contents across reset; loading is allowed while in reset.
  always_ff @(posedge clk) begin
    if (imem_we) r_imem[imem_addr[IA:1]] <= imem_wdata;
    if (rst && mem_write) r_dmem[mem_addr[DA:1]] <= mem_data;
  end

endmodule

// File: tb/tb_proc_hier_unpipelined.sv
// tb/tb_proc_hier_unpipelined.sv - directed bench for proc_hier_unpipelined
module tb_proc_hier_unpipelined;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        imem_we = 1'b0;
  logic [15:0] imem_addr = 16'd0;
  logic [15:0] imem_wdata = 16'd0;
  logic [15:0] pc, inst, write_data, mem_addr, mem_data;
  logic        reg_write, mem_read, mem_write, halt;
  logic [2:0]  write_reg;
  logic [31:0] cycle_count;

  int n_vec = 0;
  int n_err = 0;
  logic [15:0] prog [$];

  always #5 clk = ~clk;

  proc_hier_unpipelined dut (
    .clk(clk), .rst(rst), .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .pc(pc), .inst(inst), .reg_write(reg_write), .write_reg(write_reg), .write_data(write_data),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr), .mem_data(mem_data),
    .halt(halt), .cycle_count(cycle_count)
  );

  function automatic logic [15:0] e_i(input logic [4:0] op, input logic [2:0] rs, input logic [2:0] rd, input logic [4:0] imm);
    return {op, rs, rd, imm};
  endfunction
  function automatic logic [15:0] e_r(input logic [2:0] rs, input logic [2:0] rt, input logic [2:0] rd, input logic [1:0] fn);
    return {5'b11011, rs, rt, rd, fn};
  endfunction
  function automatic logic [15:0] e_b(input logic [4:0] op, input logic [2:0] rs, input logic [7:0] imm);
    return {op, rs, imm};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic release_rst();
    @(negedge clk);
    rst = 1'b1;
    #1;
  endtask

  task automatic load_prog();
    rst = 1'b0;
    #1;
    for (int i = 0; i < prog.size(); i++) begin
      imem_we    = 1'b1;
      imem_addr  = 16'(2 * i);
      imem_wdata = prog[i];
      @(posedge clk);
      #1;
    end
    imem_we = 1'b0;
    release_rst();
  endtask

  initial begin
    // HALT at address 0
    prog.delete();
    prog.push_back(16'h0000);
    load_prog();
    chk("t1_pc", pc, 16'h0000);
    chk("t1_halt", halt, 1'b1);
    chk("t1_rw", reg_write, 1'b0);
    chk("t1_cyc0", cycle_count, 32'd0);
    step(); step();
    chk("t1_pc_hold", pc, 16'h0000);
    chk("t1_halt_hold", halt, 1'b1);
    chk("t1_cyc2", cycle_count, 32'd2);

    // LBI / LBI / ADD / HALT
    prog.delete();
    prog.push_back(e_b(5'b11000, 3'd1, 8'h05));
    prog.push_back(e_b(5'b11000, 3'd2, 8'hFD));
    prog.push_back(e_r(3'd1, 3'd2, 3'd3, 2'b00));
    prog.push_back(16'h0000);
    load_prog();
    chk("t2_pc0", pc, 16'h0000);
    chk("t2_rw0", reg_write, 1'b1);
    chk("t2_wr0", write_reg, 3'd1);
    chk("t2_wd0", write_data, 16'h0005);
    step();
    chk("t2_pc1", pc, 16'h0002);
    chk("t2_wr1", write_reg, 3'd2);
    chk("t2_wd1", write_data, 16'hFFFD);
    step();
    chk("t2_pc2", pc, 16'h0004);
    chk("t2_wr2", write_reg, 3'd3);
    chk("t2_wd2", write_data, 16'h0002);
    step();
    chk("t2_pc3", pc, 16'h0006);
    chk("t2_halt", halt, 1'b1);
    chk("t2_wd_halt", write_data, 16'h0000);
    step();
    chk("t2_pc_frozen", pc, 16'h0006);

    // store then load
    prog.delete();
    prog.push_back(e_b(5'b11000, 3'd1, 8'h40));
    prog.push_back(e_b(5'b11000, 3'd2, 8'h7F));
    prog.push_back(e_i(5'b10000, 3'd1, 3'd2, 5'd2));
    prog.push_back(e_i(5'b10001, 3'd1, 3'd4, 5'd2));
    prog.push_back(16'h0000);
    load_prog();
    step(); step();
    chk("t3_st_pc", pc, 16'h0004);
    chk("t3_st_mw", mem_write, 1'b1);
    chk("t3_st_rw", reg_write, 1'b0);
    chk("t3_st_addr", mem_addr, 16'h0042);
    chk("t3_st_data", mem_data, 16'h007F);
    step();
    chk("t3_ld_mr", mem_read, 1'b1);
    chk("t3_ld_mw", mem_write, 1'b0);
    chk("t3_ld_rw", reg_write, 1'b1);
    chk("t3_ld_wr", write_reg, 3'd4);
    chk("t3_ld_wd", write_data, 16'h007F);
    chk("t3_ld_md", mem_data, 16'h0000);

    // branches
    prog.delete();
    prog.push_back(e_b(5'b11000, 3'd1, 8'h00));
    prog.push_back(e_b(5'b01100, 3'd1, 8'h02));
    prog.push_back(16'h0000);
    prog.push_back(e_b(5'b11000, 3'd1, 8'h01));
    prog.push_back(e_b(5'b01101, 3'd1, 8'h02));
    prog.push_back(16'h0000);
    prog.push_back(e_b(5'b01100, 3'd1, 8'h02));
    prog.push_back({5'b00100, 11'h7FE});
    prog.push_back(16'h0000);
    load_prog();
    step();
    chk("t4_beqz_pc", pc, 16'h0002);
    step();
    chk("t4_beqz_taken", pc, 16'h0006);
    step();
    chk("t4_bnez_pc", pc, 16'h0008);
    step();
    chk("t4_bnez_taken", pc, 16'h000C);
    step();
    chk("t4_beqz_not_taken", pc, 16'h000E);
    step();
    chk("t4_j_loop1", pc, 16'h000E);
    step();
    chk("t4_j_loop2", pc, 16'h000E);
    chk("t4_j_halt", halt, 1'b0);
    chk("t4_cyc", cycle_count, 32'd7);

    // arithmetic corners
    prog.delete();
    prog.push_back(e_b(5'b11000, 3'd1, 8'h01));
    prog.push_back(e_r(3'd1, 3'd0, 3'd5, 2'b01));
    prog.push_back(e_b(5'b11000, 3'd2, 8'h80));
    prog.push_back(e_r(3'd2, 3'd2, 3'd3, 2'b00));
    prog.push_back(e_r(3'd3, 3'd3, 3'd4, 2'b00));
    for (int i = 0; i < 3; i++) prog.push_back(e_r(3'd4, 3'd4, 3'd4, 2'b00));
    prog.push_back(e_b(5'b11000, 3'd6, 8'hF0));
    prog.push_back(e_r(3'd6, 3'd4, 3'd7, 2'b10));
    prog.push_back(e_r(3'd3, 3'd7, 3'd5, 2'b10));
    prog.push_back(e_r(3'd3, 3'd7, 3'd5, 2'b11));
    for (int i = 0; i < 3; i++) prog.push_back(e_r(3'd4, 3'd4, 3'd4, 2'b00));
    prog.push_back(e_i(5'b01000, 3'd4, 3'd4, 5'h1F));
    prog.push_back(e_i(5'b01000, 3'd4, 3'd4, 5'h01));
    prog.push_back(16'hF800);
    prog.push_back(16'h0000);
    load_prog();
    step();
    chk("t5_sub_wr", write_reg, 3'd5);
    chk("t5_sub_wd", write_data, 16'hFFFF);
    step(); step();
    chk("t5_add_wd", write_data, 16'hFF00);
    for (int i = 0; i < 6; i++) step();
    chk("t5_xor1_pc", pc, 16'h0012);
    chk("t5_xor1_wd", write_data, 16'h0FF0);
    step();
    chk("t5_xor2_wd", write_data, 16'hF0F0);
    step();
    chk("t5_and_wd", write_data, 16'h0F00);
    for (int i = 0; i < 4; i++) step();
    chk("t5_addi_m1", write_data, 16'h7FFF);
    step();
    chk("t5_addi_ovf", write_data, 16'h8000);
    step();
    chk("t5_undef_pc", pc, 16'h0022);
    chk("t5_undef_rw", reg_write, 1'b0);
    chk("t5_undef_mw", mem_write, 1'b0);
    chk("t5_undef_mr", mem_read, 1'b0);
    step();
    chk("t5_undef_next", pc, 16'h0024);
    chk("t5_end_halt", halt, 1'b1);

    // mid-program reset
    prog.delete();
    prog.push_back(e_r(3'd3, 3'd3, 3'd5, 2'b00));
    prog.push_back(e_b(5'b11000, 3'd3, 8'h80));
    prog.push_back(e_b(5'b11000, 3'd1, 8'h40));
    prog.push_back(e_i(5'b10001, 3'd1, 3'd6, 5'd2));
    prog.push_back({5'b00100, 11'h7FE});
    load_prog();
    chk("t6_first_add", write_data, 16'h0000);
    for (int i = 0; i < 4; i++) step();
    chk("t6_loop_pc", pc, 16'h0008);
    #2;
    rst = 1'b0;
    #1;
    chk("t6_async_pc", pc, 16'h0000);
    chk("t6_async_cyc", cycle_count, 32'd0);
    release_rst();
    chk("t6_restart_pc", pc, 16'h0000);
    chk("t6_regs_cleared", write_data, 16'h0000);
    step(); step(); step();
    chk("t6_ld_pc", pc, 16'h0006);
    chk("t6_ld_preserved", write_data, 16'h007F);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
